// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one seconds countdown between NREQ requesters.
// Fetches the owner's interval from the parameter table, counts 1 Hz ticks, pulses done.
module timer_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 2,
    parameter int unsigned TW   = 4
) (
    input  logic               clk,
    input  logic               sys_reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_interval,
    output logic [AW-1:0]      interval_address,
    input  logic [TW-1:0]      time_value,
    input  logic               one_hz_enable,
    output logic               divider_reset,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [TW-1:0]      remaining
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StCount, StDone} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;
    logic [TW-1:0]   remaining_q, remaining_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            div_rst_q, div_rst_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   owner_q, owner_d;

    logic [IW-1:0]   pick;
    logic            pick_valid;
    logic            owner_req;

    // First pending request scanning upward from the slot after the last owner.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            if (!pick_valid && req[(int'(last_q) + i) % int'(NREQ)]) begin
                pick_valid = 1'b1;
                pick       = IW'((int'(last_q) + i) % int'(NREQ));
            end
        end
    end

    assign owner_req = req[owner_q];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        busy_d      = busy_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        div_rst_d   = 1'b0;
        last_d      = last_q;
        owner_d     = owner_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    for (int i = 0; i < int'(NREQ); i++) begin
                        grant_d[i] = (pick == IW'(i));
                        if (pick == IW'(i)) begin
                            addr_d = req_interval[i*int'(AW) +: AW];
                        end
                    end
                    owner_d = pick;
                    busy_d  = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch, StLoad, StCount: begin
                if (!owner_req) begin
                    // Abort: release silently, but still rotate priority past this owner.
                    state_d     = StIdle;
                    grant_d     = '0;
                    busy_d      = 1'b0;
                    remaining_d = '0;
                    last_d      = owner_q;
                end else if (state_q == StFetch) begin
                    state_d   = StLoad;
                    div_rst_d = 1'b1;
                end else if (state_q == StLoad) begin
                    remaining_d = time_value;
                    state_d     = StCount;
                    if (time_value == '0) begin
                        state_d = StDone;
                        done_d  = grant_q;
                        grant_d = '0;
                        busy_d  = 1'b0;
                    end
                end else if (one_hz_enable) begin
                    remaining_d = remaining_q - TW'(1);
                    if (remaining_q == TW'(1)) begin
                        state_d = StDone;
                        done_d  = grant_q;
                        grant_d = '0;
                        busy_d  = 1'b0;
                    end
                end
            end
            StDone: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            remaining_q <= '0;
            addr_q      <= '0;
            div_rst_q   <= 1'b0;
            last_q      <= IW'(NREQ - 1);
            owner_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            div_rst_q   <= div_rst_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
        end
    end

    assign interval_address = addr_q;
    assign divider_reset    = div_rst_q;
    assign grant            = grant_q;
    assign done             = done_q;
    assign busy             = busy_q;
    assign remaining        = remaining_q;

    grant_onehot0: assert property (@(posedge clk) disable iff (!sys_reset) $onehot0(grant_q));
    done_onehot0:  assert property (@(posedge clk) disable iff (!sys_reset) $onehot0(done_q));

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed and randomized checks of timer_arbiter against a cycle-step transaction model.
module tb_timer_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 2;
    localparam int TW   = 4;
    localparam int RW   = NREQ * AW;

    logic            clk;
    logic            sys_reset;
    logic [NREQ-1:0] req;
    logic [RW-1:0]   req_interval;
    logic [AW-1:0]   interval_address;
    logic [TW-1:0]   time_value;
    logic            one_hz_enable;
    logic            divider_reset;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic            busy;
    logic [TW-1:0]   remaining;

    timer_arbiter #(.NREQ(NREQ), .AW(AW), .TW(TW)) dut (
        .clk              (clk),
        .sys_reset        (sys_reset),
        .req              (req),
        .req_interval     (req_interval),
        .interval_address (interval_address),
        .time_value       (time_value),
        .one_hz_enable    (one_hz_enable),
        .divider_reset    (divider_reset),
        .grant            (grant),
        .done             (done),
        .busy             (busy),
        .remaining        (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_done0  = 0;
    int n_done1  = 0;

    logic [TW-1:0] tbl [4];

    // Model: who owns the timer, how many cycles since grant, and seconds left.
    int              m_owner;
    int              m_done_owner;
    int              m_last;
    int              m_age;
    logic [NREQ-1:0] e_grant;
    logic [NREQ-1:0] e_done;
    logic            e_busy;
    logic [TW-1:0]   e_rem;
    logic [AW-1:0]   e_addr;
    logic            e_div;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner      = -1;
        m_done_owner = -1;
        m_last       = NREQ - 1;
        m_age        = 0;
        e_grant      = '0;
        e_done       = '0;
        e_busy       = 1'b0;
        e_rem        = '0;
        e_addr       = '0;
        e_div        = 1'b0;
    endtask

    task automatic model_finish();
        e_done       = e_grant;
        e_grant      = '0;
        e_busy       = 1'b0;
        m_done_owner = m_owner;
        m_owner      = -1;
    endtask

    // Advance the model across one clock edge using the inputs currently applied.
    task automatic model_edge();
        int p;
        if (!sys_reset) begin
            model_reset();
            return;
        end
        e_done = '0;
        e_div  = 1'b0;
        if (m_owner < 0) begin
            if (m_done_owner >= 0) begin
                m_last       = m_done_owner;
                m_done_owner = -1;
            end else begin
                p = rr_pick(req, m_last);
                if (p >= 0) begin
                    m_owner    = p;
                    m_age      = 0;
                    e_grant    = '0;
                    e_grant[p] = 1'b1;
                    e_busy     = 1'b1;
                    e_addr     = req_interval[p*AW +: AW];
                end
            end
        end else if (!req[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
            e_grant = '0;
            e_busy  = 1'b0;
            e_rem   = '0;
        end else if (m_age == 0) begin
            m_age = 1;
            e_div = 1'b1;
        end else if (m_age == 1) begin
            m_age = 2;
            e_rem = time_value;
            if (time_value == '0) model_finish();
        end else if (one_hz_enable) begin
            e_rem = e_rem - 1'b1;
            if (e_rem == '0) model_finish();
        end
    endtask

    task automatic step(input string tag);
        logic [AW-1:0] prev;
        prev = interval_address;
        model_edge();
        @(posedge clk);
        #1;
        time_value = tbl[prev];
        check(tag, 32'({grant, done, busy, remaining, interval_address, divider_reset}),
              32'({e_grant, e_done, e_busy, e_rem, e_addr, e_div}));
        if (done[0]) n_done0++;
        if (done[1]) n_done1++;
    endtask

    task automatic do_reset();
        sys_reset = 1'b0;
        step("rst");
        step("rst");
        sys_reset = 1'b1;
        n_done0   = 0;
        n_done1   = 0;
    endtask

    initial begin
        logic [NREQ-1:0] first_done;
        int              first_idx;

        sys_reset     = 1'b0;
        req           = '0;
        req_interval  = '0;
        one_hz_enable = 1'b0;
        time_value    = '0;
        tbl[0] = 4'd3;
        tbl[1] = 4'd0;
        tbl[2] = 4'd2;
        tbl[3] = 4'd4;
        model_reset();
        #1;
        check("reset_state", 32'({grant, done, busy, remaining, interval_address, divider_reset}),
              32'd0);
        do_reset();

        // Single requester, value 3, tick every 4th cycle.
        req_interval = {2'd1, 2'd0};
        req          = 2'b01;
        for (int i = 0; i < 16; i++) begin
            one_hz_enable = (i % 4 == 3);
            step("single");
            if (done[0]) req[0] = 1'b0;
        end
        one_hz_enable = 1'b0;
        check("single_done_cnt", 32'(n_done0), 32'd1);

        // Both requesting from reset: 0 first, then alternation.
        do_reset();
        req_interval = {2'd1, 2'd2};
        req          = 2'b11;
        first_done   = '0;
        for (int i = 0; i < 24; i++) begin
            one_hz_enable = (i % 2 == 1);
            step("both");
            if (first_done == '0) first_done = done;
        end
        one_hz_enable = 1'b0;
        check("both_first_owner", 32'(first_done), 32'd1);
        check("both_req1_served", 32'(n_done1 > 0), 32'd1);

        // Zero interval: done at N+3 with no ticks.
        do_reset();
        req_interval = {2'd0, 2'd1};
        req          = 2'b01;
        first_idx    = -1;
        for (int i = 0; i < 4; i++) begin
            step("zero");
            if (first_idx < 0 && done[0]) first_idx = i;
        end
        req = '0;
        step("zero_idle");
        check("zero_done_cycle", 32'(first_idx), 32'd2);
        check("zero_remaining", 32'(remaining), 32'd0);

        // Abort owner 1 after one tick; pending requester 0 takes over.
        do_reset();
        req_interval = {2'd3, 2'd2};
        req          = 2'b10;
        step("abort_grant");
        req = 2'b11;
        step("abort_load");
        step("abort_count");
        one_hz_enable = 1'b1;
        step("abort_tick");
        one_hz_enable = 1'b0;
        req           = 2'b01;
        step("abort_drop");
        check("abort_grant_clr", 32'(grant), 32'd0);
        step("abort_regrant");
        check("abort_next_owner", 32'(grant), 32'd1);
        check("abort_no_done", 32'(n_done1), 32'd0);
        req = '0;
        step("abort_release");
        step("abort_idle");

        // Tick held high through LOAD must not count.
        do_reset();
        req_interval  = {2'd0, 2'd2};
        req           = 2'b01;
        one_hz_enable = 1'b1;
        step("tick_grant");
        step("tick_load");
        step("tick_capture");
        check("tick_load_ignored", 32'(remaining), 32'd2);
        step("tick_1");
        step("tick_2");
        check("tick_done", 32'(done), 32'd1);
        req           = '0;
        one_hz_enable = 1'b0;
        step("tick_idle");

        // Asynchronous reset in the middle of a countdown.
        do_reset();
        tbl[3]       = 4'd5;
        req_interval = {2'd0, 2'd3};
        req          = 2'b01;
        step("mid_grant");
        step("mid_load");
        step("mid_count");
        check("mid_remaining", 32'(remaining), 32'd5);
        #3;
        sys_reset = 1'b0;
        #1;
        model_reset();
        check("async_reset", 32'({grant, done, busy, remaining, interval_address, divider_reset}),
              32'd0);
        step("mid_hold");
        sys_reset = 1'b1;
        step("mid_regrant");
        check("post_reset_grant", 32'(grant), 32'd1);
        check("post_reset_no_done", 32'(n_done0), 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 4; k++) tbl[k] = TW'($urandom_range(0, 4));
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) req = NREQ'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) req_interval = RW'($urandom_range(0, 255));
            one_hz_enable = ($urandom_range(0, 3) == 0);
            step("random");
        end
        check("random_activity", 32'((n_done0 + n_done1) > 0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares the single 1 Hz countdown resource (time-parameter lookup plus seconds counter) between NREQ requesters, e.g. main light sequencing, walk phase and reprogram blink.
- Arbitrates round-robin among requesters and fetches the granted requester's interval value from the time-parameter table.
- Loads and runs the countdown on the divider's one-second enable, then returns a one-cycle done pulse to the owner.
- Sits between the requesting FSMs and the TimeParameters/Divider blocks, replacing point-to-point start_timer/expired wiring.

Parameters:
NREQ, 2, number of requesters (2..4)
AW, 2, interval address width
TW, 4, time value width (seconds)

Ports:
clk  in  1  system clock
sys_reset  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester timer request, level; held until done or dropped to abort
req_interval  in  NREQ*AW  per-requester interval address; requester i uses bits [i*AW +: AW]
interval_address  out  AW  address to time-parameter table
time_value  in  TW  table read data, valid 1 cycle after interval_address is driven
one_hz_enable  in  1  one-cycle pulse per second from divider
divider_reset  out  1  one-cycle pulse realigning divider at countdown load
grant  out  NREQ  one-hot owner of the timer, zero when idle
done  out  NREQ  one-cycle expiry pulse to the owner
busy  out  1  timer owned
remaining  out  TW  seconds left in the current countdown

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on sys_reset; all state is cleared immediately on assertion.
- Reset values:
  - grant=0, done=0, busy=0, remaining=0, interval_address=0, divider_reset=0.
  - FSM in IDLE; round-robin pointer last=NREQ-1, so requester 0 has first priority.
- All outputs are registered.
- IDLE:
  - If any req is high, pick the first set req scanning from (last+1) mod NREQ upward with wrap.
  - Set grant one-hot, busy=1, latch the requester's req_interval onto interval_address; go to FETCH.
- FETCH: wait one cycle for the table read; go to LOAD.
- LOAD:
  - Capture time_value into the counter and remaining, and pulse divider_reset for this one cycle.
  - If time_value==0, go straight to DONE (no tick waited); otherwise go to COUNT.
- COUNT:
  - On each one_hz_enable, decrement remaining.
  - When remaining==1 and one_hz_enable is high, remaining becomes 0 and the FSM goes to DONE.
- DONE:
  - Pulse done[owner] for one cycle and clear grant/busy.
  - Set last=owner and return to IDLE.
  - A new grant is never issued in the DONE cycle; at least one IDLE cycle separates owners.
- Latency:
  - req rising in IDLE at cycle N gives grant at N+1, FETCH at N+1, LOAD at N+2, COUNT from N+3.
  - done is high in the cycle after the V-th one_hz_enable seen in COUNT.
- Abort:
  - If req[owner] goes low in FETCH, LOAD or COUNT, go to IDLE on the next edge.
  - grant clears, done is NOT pulsed, remaining is set to 0, and last=owner (pointer still advances).
- one_hz_enable is ignored in IDLE, FETCH, LOAD and DONE; a tick coinciding with LOAD is dropped.
- req_interval changes after the grant have no effect; the address is latched at grant.
- Requests from non-owners are held pending and never preempt the current owner.
- Simultaneous requests with last=0 and NREQ=2 grant requester 1 first.
- done and grant are never both high for the same requester in the same cycle.
- Async reset in mid-COUNT aborts immediately: no done pulse, pointer back to its reset value.
- Width: remaining is TW bits with no wrap; a decrement below 0 is unreachable by construction.
- RTL asserts: grant is one-hot or zero, and done is one-hot or zero.

Test Plan:
- Single requester, time_value=3:
  - req[0] held → grant=01 at N+1, interval_address=req_interval[0], divider_reset pulse at N+2.
  - remaining goes 3→2→1→0 over three ticks; done=01 for one cycle after the 3rd tick; busy low after.
- Both req high from reset:
  - Requester 0 is granted first (last=1 at reset); done[0] fires.
  - Requester 1 is granted after exactly one IDLE cycle; then requester 0 again if still requesting (alternation).
- time_value=0: done pulses at N+3 with no one_hz_enable applied; remaining stays 0.
- Abort: drop req[1] after 1 of 4 ticks → grant clears next cycle, no done, and a pending req[0] is granted after IDLE.
- Tick alignment:
  - one_hz_enable asserted in the LOAD cycle is ignored (remaining unchanged).
  - With value 2, done needs two subsequent ticks.
- sys_reset pulled low mid-COUNT (remaining=5) → all outputs 0 immediately, no done.
  - After release, a fresh req[0] is granted normally.
